// File: rtl/sdf_bfly_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage.
// Ports: clk/rst (async low), in_* beat + flush, out_* beat, ovf, frame_err.
//   in_valid/in_ready/in_start/in_real/in_img : input beat handshake
//   flush                                     : drain stored differences
//   out_valid/out_start/out_last/out_diff     : output beat + framing
//   out_tw_idx                                : twiddle index on diffs
//   out_real/out_img                          : output sample
//   ovf/frame_err                             : sticky status flags
// Macro SDF_BFLY_SCALE_EN: halve every result instead of saturating.
module sdf_bfly_stage #(
   parameter int DW    = 16,
   parameter int LOG2D = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_start,
   input  logic [DW-1:0]    in_real,
   input  logic [DW-1:0]    in_img,
   input  logic             flush,
   output logic             out_valid,
   output logic             out_start,
   output logic             out_last,
   output logic             out_diff,
   output logic [LOG2D-1:0] out_tw_idx,
   output logic [DW-1:0]    out_real,
   output logic [DW-1:0]    out_img,
   output logic             ovf,
   output logic             frame_err
);

   localparam int D = 1 << LOG2D;

   typedef enum logic [1:0] {FIRST, SECOND, DRAIN} state_t;

   state_t           r_state;
   logic [LOG2D-1:0] r_cnt;
   logic             r_pend;
   logic [2*DW-1:0]  r_dly [D];

   logic             r_out_valid;
   logic             r_out_start;
   logic             r_out_last;
   logic             r_out_diff;
   logic [LOG2D-1:0] r_out_tw;
   logic [DW-1:0]    r_out_re;
   logic [DW-1:0]    r_out_im;
   logic             r_ovf;
   logic             r_ferr;

   // {clip, value}: clamp a DW+1 bit result into DW bits
   function automatic logic [DW:0] f_sat(input logic [DW:0] x);
      if (x[DW] != x[DW-1])
         return {1'b1, x[DW], {(DW-1){~x[DW]}}};
      else
         return {1'b0, x[DW-1:0]};
   endfunction

   function automatic logic [DW:0] f_red(input logic [DW:0] x);
`ifdef SDF_BFLY_SCALE_EN
      logic [DW+1:0] t;
      logic [DW:0]   f;
      t = {x[DW], x} + (DW+2)'(1);
      t = {t[DW+1], t[DW+1:1]};
      // only +2^(DW-1) can exceed range; clamp it silently
      f = f_sat(t[DW:0]);
      return {1'b0, f[DW-1:0]};
`else
      return f_sat(x);
`endif
   endfunction

   logic            w_last;
   logic            w_flush_ok;
   logic            w_acc;
   logic            w_bad0;
   logic            w_restart;
   logic            w_first;
   logic            w_second;
   logic [2*DW-1:0] w_rd;
   logic [DW-1:0]   w_a_re;
   logic [DW-1:0]   w_a_im;
   logic [DW:0]     w_s_re;
   logic [DW:0]     w_s_im;
   logic [DW:0]     w_d_re;
   logic [DW:0]     w_d_im;
   logic [DW:0]     w_rs_re;
   logic [DW:0]     w_rs_im;
   logic [DW:0]     w_rd_re;
   logic [DW:0]     w_rd_im;
   logic            w_clip;
   logic            w_we;
   logic [LOG2D-1:0] w_waddr;
   logic [2*DW-1:0] w_wdata;

   assign w_last = &r_cnt;
   assign w_rd   = r_dly[r_cnt];
   assign w_a_re = w_rd[2*DW-1:DW];
   assign w_a_im = w_rd[DW-1:0];

   assign w_flush_ok = flush && (r_state == FIRST)
                    && (r_cnt == '0) && r_pend;

   // a flush that is taken blocks the beat in the same cycle
   assign in_ready = (r_state != DRAIN) && !w_flush_ok;
   assign w_acc    = in_valid && in_ready;

   assign w_bad0    = w_acc && (r_state == FIRST)
                   && (r_cnt == '0) && !in_start;
   assign w_restart = w_acc && in_start
                   && ((r_state == SECOND) || (r_cnt != '0));
   assign w_first   = w_acc && (r_state == FIRST)
                   && !w_bad0 && !w_restart;
   assign w_second  = w_acc && (r_state == SECOND) && !w_restart;

   assign w_s_re = {w_a_re[DW-1], w_a_re} + {in_real[DW-1], in_real};
   assign w_s_im = {w_a_im[DW-1], w_a_im} + {in_img[DW-1], in_img};
   assign w_d_re = {w_a_re[DW-1], w_a_re} - {in_real[DW-1], in_real};
   assign w_d_im = {w_a_im[DW-1], w_a_im} - {in_img[DW-1], in_img};

   assign w_rs_re = f_red(w_s_re);
   assign w_rs_im = f_red(w_s_im);
   assign w_rd_re = f_red(w_d_re);
   assign w_rd_im = f_red(w_d_im);

   assign w_clip = w_rs_re[DW] | w_rs_im[DW]
                 | w_rd_re[DW] | w_rd_im[DW];

   assign w_we    = w_first | w_restart | w_second;
   assign w_waddr = w_restart ? '0 : r_cnt;
   assign w_wdata = w_second
                  ? {w_rd_re[DW-1:0], w_rd_im[DW-1:0]}
                  : {in_real, in_img};

   // delay line needs no reset: stale words are never emitted
   always_ff @(posedge clk) begin
      if (w_we)
         r_dly[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= FIRST;
         r_cnt       <= '0;
         r_pend      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_start <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_diff  <= 1'b0;
         r_out_tw    <= '0;
         r_out_re    <= '0;
         r_out_im    <= '0;
         r_ovf       <= 1'b0;
         r_ferr      <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_start <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_diff  <= 1'b0;
         r_out_tw    <= '0;
         r_out_re    <= '0;
         r_out_im    <= '0;
         unique case (1'b1)
            w_flush_ok: begin
               r_state <= DRAIN;
            end
            (r_state == DRAIN): begin
               r_out_valid <= 1'b1;
               r_out_diff  <= 1'b1;
               r_out_tw    <= r_cnt;
               r_out_last  <= w_last;
               r_out_re    <= w_a_re;
               r_out_im    <= w_a_im;
               r_cnt       <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= FIRST;
                  r_pend  <= 1'b0;
               end
            end
            w_bad0: begin
               r_ferr <= 1'b1;
            end
            w_restart: begin
               r_ferr  <= 1'b1;
               r_pend  <= 1'b0;
               r_state <= FIRST;
               r_cnt   <= LOG2D'(1);
            end
            w_first: begin
               if (r_pend) begin
                  r_out_valid <= 1'b1;
                  r_out_diff  <= 1'b1;
                  r_out_tw    <= r_cnt;
                  r_out_last  <= w_last;
                  r_out_re    <= w_a_re;
                  r_out_im    <= w_a_im;
               end
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= SECOND;
                  r_pend  <= 1'b0;
               end
            end
            w_second: begin
               r_out_valid <= 1'b1;
               r_out_start <= (r_cnt == '0);
               r_out_re    <= w_rs_re[DW-1:0];
               r_out_im    <= w_rs_im[DW-1:0];
               r_cnt       <= r_cnt + 1'b1;
               if (w_clip)
                  r_ovf <= 1'b1;
               if (w_last) begin
                  r_state <= FIRST;
                  r_pend  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid  = r_out_valid;
   assign out_start  = r_out_start;
   assign out_last   = r_out_last;
   assign out_diff   = r_out_diff;
   assign out_tw_idx = r_out_tw;
   assign out_real   = r_out_re;
   assign out_img    = r_out_im;
   assign ovf        = r_ovf;
   assign frame_err  = r_ferr;

endmodule

// File: tb/tb_sdf_bfly_stage.sv
// Scoreboard bench for sdf_bfly_stage (DW=16, LOG2D=2).
// Frame-level reference model; monitor compares every output beat.
module tb_sdf_bfly_stage;

   localparam int DW    = 16;
   localparam int LOG2D = 2;
   localparam int D     = 1 << LOG2D;
   localparam int MAXV  = (1 << (DW-1)) - 1;
   localparam int MINV  = -(1 << (DW-1));

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             in_start;
   logic [DW-1:0]    in_real;
   logic [DW-1:0]    in_img;
   logic             flush;
   logic             out_valid;
   logic             out_start;
   logic             out_last;
   logic             out_diff;
   logic [LOG2D-1:0] out_tw_idx;
   logic [DW-1:0]    out_real;
   logic [DW-1:0]    out_img;
   logic             ovf;
   logic             frame_err;

   always #5 clk = ~clk;

   sdf_bfly_stage #(.DW(DW), .LOG2D(LOG2D)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_start   (in_start),
      .in_real    (in_real),
      .in_img     (in_img),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_start  (out_start),
      .out_last   (out_last),
      .out_diff   (out_diff),
      .out_tw_idx (out_tw_idx),
      .out_real   (out_real),
      .out_img    (out_img),
      .ovf        (ovf),
      .frame_err  (frame_err)
   );

   typedef struct packed {
      logic             st;
      logic             la;
      logic             df;
      logic [LOG2D-1:0] idx;
      logic [DW-1:0]    re;
      logic [DW-1:0]    im;
      logic             ov;
      logic             fe;
   } beat_t;

   beat_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   // reference model state
   int cur_re[$];
   int cur_im[$];
   int pend_re[D];
   int pend_im[D];
   int nd_re[D];
   int nd_im[D];
   bit pend_ok;
   bit m_ovf;
   bit m_ferr;
   int drain_left;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   function automatic int red(input int x);
`ifdef SDF_BFLY_SCALE_EN
      int t;
      t = (x + 1) >>> 1;
      if (t > MAXV) t = MAXV;
      return t;
`else
      if (x > MAXV) begin
         m_ovf = 1'b1;
         return MAXV;
      end
      if (x < MINV) begin
         m_ovf = 1'b1;
         return MINV;
      end
      return x;
`endif
   endfunction

   function automatic void push(input bit st, input bit la,
                                input bit df, input int idx,
                                input int re, input int im);
      beat_t b;
      b.st  = st;
      b.la  = la;
      b.df  = df;
      b.idx = LOG2D'(idx);
      b.re  = DW'(re);
      b.im  = DW'(im);
      b.ov  = m_ovf;
      b.fe  = m_ferr;
      exp_q.push_back(b);
   endfunction

   function automatic void model_reset();
      cur_re.delete();
      cur_im.delete();
      pend_ok    = 1'b0;
      m_ovf      = 1'b0;
      m_ferr     = 1'b0;
      drain_left = 0;
      exp_q.delete();
   endfunction

   // one accepted sample, in frame terms
   function automatic void model_beat(input bit st, input int re,
                                      input int im);
      int pos;
      int k;
      int sr, si;
      pos = cur_re.size();
      if (pos == 0 && !st) begin
         m_ferr = 1'b1;
         return;
      end
      if (st && pos != 0) begin
         m_ferr  = 1'b1;
         pend_ok = 1'b0;
         cur_re.delete();
         cur_im.delete();
         cur_re.push_back(re);
         cur_im.push_back(im);
         return;
      end
      if (pos < D) begin
         if (pend_ok)
            push(0, pos == D-1, 1, pos, pend_re[pos], pend_im[pos]);
         cur_re.push_back(re);
         cur_im.push_back(im);
         if (pos == D-1) pend_ok = 1'b0;
      end else begin
         k        = pos - D;
         sr       = red(cur_re[k] + re);
         si       = red(cur_im[k] + im);
         nd_re[k] = red(cur_re[k] - re);
         nd_im[k] = red(cur_im[k] - im);
         push(k == 0, 0, 0, 0, sr, si);
         cur_re.push_back(re);
         cur_im.push_back(im);
         if (pos == 2*D-1) begin
            pend_re = nd_re;
            pend_im = nd_im;
            pend_ok = 1'b1;
            cur_re.delete();
            cur_im.delete();
         end
      end
   endfunction

   task automatic beat(input bit v, input bit st, input int re,
                       input int im, input bit fl, output bit acc);
      bit rdy_e;
      @(negedge clk);
      in_valid = v;
      in_start = st;
      in_real  = DW'(re);
      in_img   = DW'(im);
      flush    = fl;
      acc      = 1'b0;
      if (drain_left > 0) begin
         rdy_e = 1'b0;
         drain_left--;
      end else if (fl && cur_re.size() == 0 && pend_ok) begin
         rdy_e = 1'b0;
         for (int k = 0; k < D; k++)
            push(0, k == D-1, 1, k, pend_re[k], pend_im[k]);
         pend_ok    = 1'b0;
         drain_left = D;
      end else begin
         rdy_e = 1'b1;
         if (v) begin
            acc = 1'b1;
            model_beat(st, re, im);
         end
      end
      #1;
      chk("in_ready", int'(in_ready), int'(rdy_e));
   endtask

   task automatic send(input int re, input int im, input bit st);
      bit a;
      a = 1'b0;
      for (int t = 0; t < 2*D+2 && !a; t++)
         beat(1'b1, st, re, im, 1'b0, a);
      if (!a) begin
         failures++;
         $display("FAIL send_timeout got=0 exp=1");
      end
   endtask

   task automatic idle(input int n, input bit fl, input bit v);
      bit a;
      for (int i = 0; i < n; i++)
         beat(v, 1'b0, 99, 0, fl, a);
   endtask

   function automatic int rnd(input int span);
      return int'($urandom_range(0, 2*span)) - span;
   endfunction

   // monitor: every output beat is popped and compared
   always @(negedge clk) begin
      beat_t act;
      beat_t e;
      if (out_valid) begin
         act.st  = out_start;
         act.la  = out_last;
         act.df  = out_diff;
         act.idx = out_tw_idx;
         act.re  = out_real;
         act.im  = out_img;
         act.ov  = ovf;
         act.fe  = frame_err;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected got=%h exp=none", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               failures++;
               $display("FAIL out_beat got=%h exp=%h", act, e);
            end
         end
      end
   end

   int f1[8]  = '{1, 2, 3, 4, 10, 20, 30, 40};
   int fov[8] = '{32767, 0, 0, 0, 1, 0, 0, 0};

   initial begin
      bit a;
      int sp;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_start = 1'b0;
      in_real  = '0;
      in_img   = '0;
      flush    = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_out_real", int'(out_real), 0);
      @(negedge clk);
      rst = 1'b1;

      // basic frame then flush, beats offered during drain
      for (int i = 0; i < 2*D; i++) send(f1[i], 0, i == 0);
      idle(1, 1'b1, 1'b0);
      idle(D, 1'b0, 1'b1);

      // saturation corner
      for (int i = 0; i < 2*D; i++) send(fov[i], 0, i == 0);
      idle(1, 1'b1, 1'b0);
      idle(D, 1'b0, 1'b0);
      chk("ovf_flag", int'(ovf), int'(m_ovf));

      // back-to-back frames, then gappy and full-range frames
      for (int f = 0; f < 8; f++) begin
         sp = (f < 4) ? 1000 : 32768;
         for (int i = 0; i < 2*D; i++) begin
            if (f >= 3 && $urandom_range(0, 3) == 0)
               idle(1, $urandom_range(0, 5) == 0, 1'b0);
            send(rnd(sp), rnd(sp), i == 0);
         end
      end
      idle(1, 1'b1, 1'b0);
      idle(D, 1'b0, 1'b0);

      // flush mid-frame is ignored; honoured flush blocks a beat
      send(5, 1, 1);
      send(6, 2, 0);
      beat(1'b1, 1'b0, 7, 3, 1'b1, a);
      for (int i = 3; i < 2*D; i++) send(i, -i, 0);
      beat(1'b1, 1'b1, 8, 0, 1'b1, a);
      idle(D, 1'b0, 1'b0);

      // framing errors: early start, missing start
      chk("ferr_before", int'(frame_err), 0);
      for (int i = 0; i < 2*D; i++) send(rnd(500), 0, i == 0);
      send(1, 0, 1);
      send(2, 0, 0);
      send(5, 0, 1);
      for (int i = 1; i < 2*D; i++) send(rnd(500), rnd(500), 0);
      send(9, 0, 0);
      chk("ferr_sticky", int'(frame_err), 1);
      for (int i = 0; i < 2*D; i++) send(rnd(500), rnd(500), i == 0);
      idle(1, 1'b1, 1'b0);
      idle(D, 1'b0, 1'b0);

      // reset in the middle of a drain
      for (int i = 0; i < 2*D; i++) send(rnd(900), rnd(900), i == 0);
      idle(1, 1'b1, 1'b0);
      idle(2, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rstd_out_valid", int'(out_valid), 0);
      chk("rstd_in_ready", int'(in_ready), 1);
      chk("rstd_ovf", int'(ovf), 0);
      chk("rstd_frame_err", int'(frame_err), 0);
      model_reset();
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // post-reset frames must carry no stale differences
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 2*D; i++)
            send(rnd(2000), rnd(2000), i == 0);
      idle(1, 1'b1, 1'b0);
      idle(D + 3, 1'b0, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("ferr_final", int'(frame_err), int'(m_ferr));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdf_bfly_stage.md
SDF_BFLY_STAGE -- requirements
Module: sdf_bfly_stage

Interface
REQ-001 SHALL have parameter DW, default 16, meaning component width, two's complement.
REQ-002 SHALL have parameter LOG2D, default 3 (minimum 1), meaning log2 of the delay depth D=2^LOG2D; frame = 2D samples.
REQ-003 SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  beat accepted when in_valid&in_ready.
- in_start  in  1  first sample of a frame.
- in_real, in_img  in  DW  input sample.
- flush  in  1  pulse; drain stored differences.
- out_valid  out  1  output beat.
- out_start  out  1  first sum beat of a frame.
- out_last  out  1  last difference beat of a frame.
- out_diff  out  1  beat is a difference (needs twiddle).
- out_tw_idx  out  LOG2D  twiddle index k on difference beats, else 0.
- out_real, out_img  out  DW  output sample.
- ovf  out  1  sticky saturation flag.
- frame_err  out  1  sticky framing-error flag.

Function
REQ-004 SHALL be a radix-2 DIF single-path delay-feedback stage: D-entry register delay line of 2*DW-bit words, LOG2D-bit counter cnt, pending flag.
REQ-005 SHALL have states FIRST, SECOND, DRAIN; cnt advances only on accepted beats (FIRST/SECOND) or every cycle (DRAIN).
REQ-006 FIRST, accepted beat: read delay[cnt] then write input there; if pending, emit it with out_diff=1, out_tw_idx=cnt, and out_last=1 when cnt=D-1. Wrap at D-1 -> SECOND, pending=0.
REQ-007 SECOND, accepted beat: a=delay[cnt], b=input; emit a+b (out_start=1 when cnt=0); write a-b to delay[cnt]. Wrap -> FIRST, pending=1.
REQ-008 Sum/difference SHALL be computed at DW+1 bits, then reduced per REQ-018 before output or storage.
REQ-009 Every output SHALL be registered one cycle after its accepted beat; out_valid=0 otherwise; no downstream backpressure.
REQ-010 in_ready SHALL be 1 in FIRST/SECOND and 0 in DRAIN.
REQ-011 flush SHALL be honoured only in FIRST with cnt=0 and pending=1 -> DRAIN; otherwise ignored. An in_valid in the same cycle is not accepted.
REQ-012 DRAIN SHALL emit delay[cnt] each cycle as a difference beat for D cycles (out_last on the last), then -> FIRST, cnt=0, pending=0.
REQ-013 A beat in FIRST at cnt=0 without in_start SHALL be discarded and SHALL set frame_err.
REQ-014 in_start on an accepted beat with cnt!=0, or in SECOND, SHALL set frame_err, clear pending, and restart as FIRST sample 0 (cnt=1 afterwards).
REQ-015 Back-to-back frames SHALL stream without gaps: the differences of frame n are emitted interleaved with the first half of frame n+1.

Reset
REQ-016 When rst is low, SHALL asynchronously set state FIRST, cnt=0, pending=0, and all outputs 0 except in_ready=1; delay contents are don't-care.
REQ-017 Reset mid-frame or mid-drain SHALL discard all stored data; the first post-reset frame emits no stale differences.

Configuration
REQ-018 Macro SDF_BFLY_SCALE_EN:
- Defined: every DW+1 result becomes (x+1)>>>1 (round half up); ovf stays 0.
- Undefined: every result saturates to [-2^(DW-1), 2^(DW-1)-1], and any clipping sets ovf.

Verification (DW=16, LOG2D=2, img=0 unless stated)
REQ-019 Frame 1,2,3,4,10,20,30,40, then flush, macro undefined -> sums 11,22,33,44 (out_start on 11); DRAIN diffs -9,-18,-27,-36 with tw_idx 0..3, out_last on -36, in_ready=0 for 4 cycles.
REQ-020 Same frame, macro defined -> sums 6,11,17,22; diffs -4,-9,-13,-18.
REQ-021 Two back-to-back frames -> frame-0 diffs appear on out during frame-1 beats 0..3 with no idle cycles; frame-1 sums follow.
REQ-022 a=32767, b=1 (macro undefined) -> sum 32767, ovf=1 and stays 1; stored diff 32766.
REQ-023 in_start at cnt=2 -> frame_err=1; the beat becomes sample 0; no difference beats are emitted for the aborted frame.
REQ-024 rst low during DRAIN cycle 2 -> out_valid=0 immediately, in_ready=1; next frame's first half emits nothing.
